led_frame_store: RTL and testbench

Double-buffered 64x64 frame store and PWM pixel source that feeds `led_driver`'s `rgb_data` input, replacing the procedural `painter` pair. A host writes RGB pixels into a hidden page. The display page is read with the `{subframe, addr, x}` sweep from the `incrementer`. Each colour channel is compared against the subframe to produce the 6-bit top/bottom half RGB stream. Page swaps occur only at frame start, so there is no tearing.

---
 rtl/led_frame_store_pkg.sv | 31 +++
 rtl/led_frame_store_if.sv | 29 ++
 rtl/led_frame_store_bank.sv | 27 ++
 rtl/led_frame_store.sv | 154 +++++++++++++++
 tb/tb_led_frame_store.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_frame_store_pkg.sv
// Shared definitions for the LED frame store: panel geometry, control FSM
// encoding and the bit layout of the rgb_data stream.
package led_pkg;

  // Panel geometry: 64 columns, 32 row pairs (top row r, bottom row r+32).
  localparam int COLS      = 64;
  localparam int ROW_PAIRS = 32;
  localparam int X_W       = $clog2(COLS);        // column index width
  localparam int ROW_W     = $clog2(ROW_PAIRS);   // row-pair index width
  localparam int PAGE_AW   = ROW_W + X_W;         // words per page = 2048
  localparam int BANK_AW   = PAGE_AW + 1;         // two pages per bank

  // rgb_data layout: {b1,g1,r1,b0,g0,r0}; channel c of half h is bit h*3+c.
  localparam int RGB_HALF_BITS = 3;
  localparam int RGB_W         = 2 * RGB_HALF_BITS;

  // Control FSM, one-hot.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_CLEAR     = 3'b010,
    ST_SWAP_WAIT = 3'b100
  } fsm_state_t;

  // First pixel of the first subframe: the only point where pages may swap.
  function automatic logic is_frame_start(input logic [7:0] sf,
                                          input logic [ROW_W-1:0] a,
                                          input logic [X_W-1:0] xx);
    return (sf == 8'd0) && (a == '0) && (xx == '0);
  endfunction

endpackage

// File: rtl/led_frame_store_if.sv
// Host-side pixel write / clear / swap port of the frame store.
interface led_frame_store_if #(
  parameter int PIXEL_BITS = 4
);
  import led_pkg::*;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [X_W-1:0]            wr_x;
  logic [ROW_W:0]            wr_y;
  logic [3*PIXEL_BITS-1:0]   wr_rgb;
  logic                      clear_req;
  logic [3*PIXEL_BITS-1:0]   clear_rgb;
  logic                      swap_req;
  logic                      swap_done;

  // Host side drives requests and sees ready / swap completion.
  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, clear_req, clear_rgb, swap_req,
    input  wr_ready, swap_done
  );

  // Frame store side.
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, clear_req, clear_rgb, swap_req,
    output wr_ready, swap_done
  );

endinterface

// File: rtl/led_frame_store_bank.sv
// Simple dual-port RAM with registered read; one instance per panel half.
module frame_bank #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port and registered read port; no reset so the array maps to EBR.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/led_frame_store.sv
// Double-buffered 64x64 frame store with PWM pixel output. The display page
// is swept by {subframe, addr, x}; the host writes and clears the other page.
module led_frame_store
  import led_pkg::*;
#(
  parameter int PIXEL_BITS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        subframe,
  input  logic [ROW_W-1:0]  addr,
  input  logic [X_W-1:0]    x,
  output logic [RGB_W-1:0]  rgb_data,
  led_frame_store_if.slave  host
);

  localparam int PIX_W = 3 * PIXEL_BITS;

  fsm_state_t                 r_state;
  logic                       r_disp_page;
  logic                       r_swap_pend;
  logic                       r_wr_ready;
  logic                       r_swap_done;
  logic [PAGE_AW-1:0]         r_clr_cnt;
  logic [PIX_W-1:0]           r_clr_rgb;
  logic [BANK_AW-1:0]         r_rd_addr;
  logic [PIXEL_BITS-1:0]      r_thr_s1;
  logic [PIXEL_BITS-1:0]      r_thr_s2;
  logic [RGB_W-1:0]           r_rgb;

  logic                       w_frame_start;
  logic                       w_commit;
  logic                       w_rd_page;
  logic                       w_wr_page;
  logic                       w_host_acc;
  logic                       w_clearing;
  logic [BANK_AW-1:0]         w_waddr;
  logic [PIX_W-1:0]           w_wdata;
  logic [1:0]                 w_we;
  logic [1:0][PIX_W-1:0]      w_rdata;
  logic [RGB_W-1:0]           w_lit;

  assign w_frame_start = is_frame_start(subframe, addr, x);
  assign w_commit      = (r_state == ST_SWAP_WAIT) && w_frame_start;
  // The read issued on the commit edge already targets the new page.
  assign w_rd_page     = r_disp_page ^ w_commit;
  assign w_wr_page     = ~r_disp_page;
  assign w_host_acc    = host.wr_valid & r_wr_ready;
  assign w_clearing    = (r_state == ST_CLEAR);

  // Clears sweep the write page of both banks; host writes hit one bank.
  assign w_waddr = w_clearing ? {w_wr_page, r_clr_cnt}
                              : {w_wr_page, host.wr_y[ROW_W-1:0], host.wr_x};
  assign w_wdata = w_clearing ? r_clr_rgb : host.wr_rgb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign w_we[gi] = w_clearing | (w_host_acc & (host.wr_y[ROW_W] == 1'(gi)));

    frame_bank #(
      .DATA_W (PIX_W),
      .ADDR_W (BANK_AW)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we[gi]),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_addr),
      .o_rdata (w_rdata[gi])
    );
  end

  // PWM: channel lit when its value exceeds the subframe threshold.
  for (genvar gi = 0; gi < RGB_W; gi++) begin : g_pwm
    assign w_lit[gi] =
      w_rdata[gi / RGB_HALF_BITS][(gi % RGB_HALF_BITS)*PIXEL_BITS +: PIXEL_BITS] > r_thr_s2;
  end

  // Read pipeline: address/threshold capture, RAM read, compare register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_addr <= '0;
      r_thr_s1  <= '0;
      r_thr_s2  <= '0;
      r_rgb     <= '0;
    end else begin
      r_rd_addr <= {w_rd_page, addr, x};
      r_thr_s1  <= subframe[7 -: PIXEL_BITS];
      r_thr_s2  <= r_thr_s1;
      r_rgb     <= w_lit;
    end
  end

  // Control FSM: host writes, page clear, and frame-aligned page swap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_disp_page <= 1'b0;
      r_swap_pend <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_swap_done <= 1'b0;
      r_clr_cnt   <= '0;
      r_clr_rgb   <= '0;
    end else begin
      r_swap_done <= 1'b0;
      if (host.swap_req) begin
        r_swap_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (host.clear_req) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_rgb  <= host.clear_rgb;
            r_wr_ready <= 1'b0;
          end else if (r_swap_pend || host.swap_req) begin
            r_state    <= ST_SWAP_WAIT;
            r_wr_ready <= 1'b0;
          end else begin
            r_wr_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (&r_clr_cnt) begin
            if (r_swap_pend || host.swap_req) begin
              r_state <= ST_SWAP_WAIT;
            end else begin
              r_state    <= ST_IDLE;
              r_wr_ready <= 1'b1;
            end
          end
        end
        ST_SWAP_WAIT: begin
          if (w_frame_start) begin
            r_disp_page <= ~r_disp_page;
            r_swap_done <= 1'b1;
            r_swap_pend <= 1'b0;
            r_state     <= ST_IDLE;
            r_wr_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wr_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rgb_data       = r_rgb;
  assign host.wr_ready  = r_wr_ready;
  assign host.swap_done = r_swap_done;

endmodule

// File: tb/tb_led_frame_store.sv
// Self-checking bench for led_frame_store: reference model is a plain
// two-page 64x64 pixel array plus the PWM rule "value > subframe[7:4]".
module tb_led_frame_store;

  localparam int PB = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] subframe = 8'd1;
  logic [4:0] addr = 5'd0;
  logic [5:0] x = 6'd0;
  logic [5:0] rgb_data;

  led_frame_store_if #(.PIXEL_BITS(PB)) host_if ();

  led_frame_store #(.PIXEL_BITS(PB)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .subframe (subframe),
    .addr     (addr),
    .x        (x),
    .rgb_data (rgb_data),
    .host     (host_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: pixel memory per page [page][y][x], and displayed page.
  logic [11:0] mem [0:1][0:63][0:63];
  int disp_m = 0;

  function automatic logic [5:0] model_rgb(input int page, input logic [7:0] sf,
                                           input logic [4:0] a, input logic [5:0] xx);
    int t, top, bot;
    logic [5:0] r;
    t   = int'(sf) / 16;
    top = int'(mem[page][int'(a)][int'(xx)]);
    bot = int'(mem[page][int'(a) + 32][int'(xx)]);
    for (int c = 0; c < 3; c++) begin
      r[c]     = ((top >> (4*c)) & 15) > t;
      r[3 + c] = ((bot >> (4*c)) & 15) > t;
    end
    return r;
  endfunction

  task automatic fill_page(input int page, input logic [11:0] v);
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++)
        mem[page][yy][xx] = v;
  endtask

  // Drive sweep inputs, advance one edge, land 1 time unit after it.
  task automatic step(input logic [7:0] sf, input logic [4:0] a, input logic [5:0] xx);
    subframe = sf;
    addr     = a;
    x        = xx;
    @(posedge clk);
    #1;
  endtask

  // One cycle with a sweep position that is never frame start.
  task automatic idle_step();
    step(8'($urandom_range(1, 255)), 5'($urandom), 6'($urandom));
  endtask

  task automatic host_write(input int xx, input int yy, input logic [11:0] v);
    n_cmp++;
    if (host_if.wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL write_ready: wr_ready=%b required 1", host_if.wr_ready);
    end
    host_if.wr_valid = 1'b1;
    host_if.wr_x     = 6'(xx);
    host_if.wr_y     = 6'(yy);
    host_if.wr_rgb   = v;
    idle_step();
    host_if.wr_valid = 1'b0;
    mem[1 - disp_m][yy][xx] = v;
    $display("write x=%0d y=%0d rgb=%03h page=%0d", xx, yy, v, 1 - disp_m);
  endtask

  task automatic start_clear(input logic [11:0] v, input logic with_swap);
    n_cmp++;
    if (host_if.wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_ready: wr_ready=%b required 1", host_if.wr_ready);
    end
    host_if.clear_req = 1'b1;
    host_if.clear_rgb = v;
    host_if.swap_req  = with_swap;
    idle_step();
    host_if.clear_req = 1'b0;
    host_if.swap_req  = 1'b0;
    fill_page(1 - disp_m, v);
    $display("clear rgb=%03h page=%0d swap=%b", v, 1 - disp_m, with_swap);
  endtask

  // Wait for a plain clear to finish, counting the busy cycles.
  task automatic wait_clear();
    int cnt = 0;
    while (host_if.wr_ready !== 1'b1 && cnt < 5000) begin
      idle_step();
      cnt++;
    end
    n_cmp++;
    if (cnt != 2048) begin
      n_bad++;
      $display("FAIL clear_len: busy %0d cycles required 2048", cnt);
    end
  endtask

  // Swap with a merged second request; commit only at frame start.
  task automatic do_swap();
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || i == 3) host_if.swap_req = 1'b1;
      idle_step();
      host_if.swap_req = 1'b0;
      n_cmp++;
      if (host_if.swap_done !== 1'b0 || host_if.wr_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL swap_wait: done=%b ready=%b required 0/0",
                 host_if.swap_done, host_if.wr_ready);
      end
    end
    step(8'd0, 5'd0, 6'd0);
    disp_m = 1 - disp_m;
    n_cmp++;
    if (host_if.swap_done !== 1'b1 || host_if.wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL swap_commit: done=%b ready=%b required 1/1",
               host_if.swap_done, host_if.wr_ready);
    end
    step(8'd0, 5'd0, 6'd0);
    n_cmp++;
    if (host_if.swap_done !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_single: done=%b required 0", host_if.swap_done);
    end
    for (int i = 0; i < 2; i++) begin
      idle_step();
      n_cmp++;
      if (rgb_data !== model_rgb(disp_m, 8'd0, 5'd0, 6'd0) || host_if.swap_done !== 1'b0) begin
        n_bad++;
        $display("FAIL swap_pixel0: rgb=%b done=%b required %b/0", rgb_data,
                 host_if.swap_done, model_rgb(disp_m, 8'd0, 5'd0, 6'd0));
      end
    end
    $display("swap committed, display page=%0d", disp_m);
  endtask

  task automatic test_reset();
    host_if.wr_valid  = 1'b0;
    host_if.wr_x      = '0;
    host_if.wr_y      = '0;
    host_if.wr_rgb    = '0;
    host_if.clear_req = 1'b0;
    host_if.clear_rgb = '0;
    host_if.swap_req  = 1'b0;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) idle_step();
    n_cmp++;
    if (rgb_data !== 6'd0 || host_if.wr_ready !== 1'b0 || host_if.swap_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rgb=%b ready=%b done=%b required 0/0/0",
               rgb_data, host_if.wr_ready, host_if.swap_done);
    end
    resetn = 1'b1;
    idle_step();
    n_cmp++;
    if (host_if.wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: wr_ready=%b required 1", host_if.wr_ready);
    end
  endtask

  task automatic test_clear_only(input logic [11:0] v);
    start_clear(v, 1'b0);
    wait_clear();
  endtask

  task automatic test_clear_swap();
    logic seen_done = 1'b0;
    start_clear(12'h0F0, 1'b1);
    for (int i = 0; i < 2100; i++) begin
      if (i == 500) step(8'd0, 5'd0, 6'd0);
      else idle_step();
      if (host_if.swap_done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0 || host_if.wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_swap_wait: early_done=%b ready=%b required 0/0",
               seen_done, host_if.wr_ready);
    end
    step(8'd0, 5'd0, 6'd0);
    disp_m = 1 - disp_m;
    n_cmp++;
    if (host_if.swap_done !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_swap_commit: done=%b required 1", host_if.swap_done);
    end
  endtask

  task automatic test_random_readback(input int n);
    logic [5:0] expq[$];
    logic [7:0] sf;
    logic [4:0] a;
    logic [5:0] xx;
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) begin
        sf = 8'($urandom);
        a  = 5'($urandom);
        xx = 6'($urandom);
        expq.push_back(model_rgb(disp_m, sf, a, xx));
        step(sf, a, xx);
      end else begin
        idle_step();
      end
      if (k >= 2) begin
        n_cmp++;
        if (rgb_data !== expq[k-2]) begin
          n_bad++;
          $display("FAIL readback[%0d]: rgb=%b required %b", k - 2, rgb_data, expq[k-2]);
        end
      end
    end
  endtask

  task automatic test_pixel_pwm();
    logic [5:0] want;
    host_write(5, 3, 12'hF00);
    host_write(5, 35, 12'h00F);
    do_swap();
    for (int s = 0; s < 258; s++) begin
      if (s < 256) step(8'(s), 5'd3, 6'd5);
      else idle_step();
      if (s >= 2) begin
        want = (s - 2 < 'hF0) ? 6'b001_100 : 6'b000_000;
        n_cmp++;
        if (rgb_data !== want) begin
          n_bad++;
          $display("FAIL pixel_pwm sf=%02h: rgb=%b required %b", s - 2, rgb_data, want);
        end
      end
    end
  endtask

  task automatic test_pwm_linear();
    int lit = 0;
    host_write(10, 7, 12'h008);
    do_swap();
    for (int s = 0; s < 258; s++) begin
      if (s < 256) step(8'(s), 5'd7, 6'd10);
      else idle_step();
      if (s >= 2) begin
        if (rgb_data[0] === 1'b1) lit++;
        n_cmp++;
        if (rgb_data[0] !== ((s - 2) < 128)) begin
          n_bad++;
          $display("FAIL pwm_r8 sf=%02h: r0=%b required %b", s - 2, rgb_data[0], (s - 2) < 128);
        end
      end
    end
    n_cmp++;
    if (lit != 128) begin
      n_bad++;
      $display("FAIL pwm_count: lit %0d subframes required 128", lit);
    end
  endtask

  task automatic test_write_on_clear();
    logic [5:0] want;
    n_cmp++;
    if (host_if.wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL woc_ready: wr_ready=%b required 1", host_if.wr_ready);
    end
    host_if.wr_valid  = 1'b1;
    host_if.wr_x      = 6'd20;
    host_if.wr_y      = 6'd40;
    host_if.wr_rgb    = 12'h5A3;
    host_if.clear_req = 1'b1;
    host_if.clear_rgb = 12'h3C7;
    idle_step();
    host_if.wr_valid  = 1'b0;
    host_if.clear_req = 1'b0;
    mem[1 - disp_m][40][20] = 12'h5A3;
    fill_page(1 - disp_m, 12'h3C7);
    $display("write+clear x=20 y=40 rgb=5a3 clear=3c7 page=%0d", 1 - disp_m);
    wait_clear();
    do_swap();
    step(8'h30, 5'd8, 6'd20);
    idle_step();
    idle_step();
    want = model_rgb(disp_m, 8'h30, 5'd8, 6'd20);
    n_cmp++;
    if (rgb_data !== want) begin
      n_bad++;
      $display("FAIL woc_pixel: rgb=%b required %b", rgb_data, want);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [5:0] want;
    host_write(63, 31, (disp_m == 1) ? 12'h00F : 12'hF00);
    do_swap();
    host_write(63, 31, (disp_m == 1) ? 12'h00F : 12'hF00);
    if (disp_m == 0) do_swap();
    // Display page 1 now; page 0 holds 00F at (63,31), page 1 holds F00.
    host_if.clear_req = 1'b1;
    host_if.clear_rgb = 12'hFFF;
    host_if.swap_req  = 1'b1;
    idle_step();
    host_if.clear_req = 1'b0;
    host_if.swap_req  = 1'b0;
    for (int i = 0; i < 100; i++) idle_step();
    resetn = 1'b0;
    #1;
    disp_m = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rgb_data !== 6'd0 || host_if.swap_done !== 1'b0 || host_if.wr_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_clear: rgb=%b done=%b ready=%b required 0/0/0",
                 rgb_data, host_if.swap_done, host_if.wr_ready);
      end
      idle_step();
    end
    resetn = 1'b1;
    idle_step();
    n_cmp++;
    if (host_if.wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release: wr_ready=%b required 1", host_if.wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(8'd0, 5'd0, 6'd0);
      n_cmp++;
      if (host_if.swap_done !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_no_swap: done=%b required 0", host_if.swap_done);
      end
    end
    step(8'h00, 5'd31, 6'd63);
    idle_step();
    idle_step();
    want = model_rgb(0, 8'h00, 5'd31, 6'd63);
    n_cmp++;
    if (rgb_data !== want) begin
      n_bad++;
      $display("FAIL rst_page0: rgb=%b required %b", rgb_data, want);
    end
  endtask

  initial begin
    test_reset();
    test_clear_only(12'($urandom));
    test_clear_swap();
    test_random_readback(200);
    test_clear_only(12'h000);
    test_pixel_pwm();
    test_pwm_linear();
    test_write_on_clear();
    test_random_readback(200);
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
